// File: rtl/jb_resolve_unit_pkg.sv
// Shared definitions for the jump/branch resolution unit.
//   - RV32I opcode field values (inst[6:2]) for the control-flow instructions
//   - funct3 encodings for the six branch conditions
//   - branch_taken(): evaluates a branch condition from precomputed compare flags
package jb_resolve_unit_pkg;

  localparam logic [4:0] OP_JAL    = 5'b11011;
  localparam logic [4:0] OP_JALR   = 5'b11001;
  localparam logic [4:0] OP_BRANCH = 5'b11000;

  typedef enum logic [2:0] {
    F3_BEQ  = 3'b000,
    F3_BNE  = 3'b001,
    F3_BLT  = 3'b100,
    F3_BGE  = 3'b101,
    F3_BLTU = 3'b110,
    F3_BGEU = 3'b111
  } br_f3_e;

  // Compare flags are computed once in the datapath so this stays width-agnostic.
  // The undefined encodings 010/011 resolve as not taken.
  function automatic logic branch_taken(input logic [2:0] f3, input logic eq,
                                        input logic lt_s, input logic lt_u);
    logic t;
    t = 1'b0;
    case (f3)
      F3_BEQ:  t = eq;
      F3_BNE:  t = !eq;
      F3_BLT:  t = lt_s;
      F3_BGE:  t = !lt_s;
      F3_BLTU: t = lt_u;
      F3_BGEU: t = !lt_u;
      default: t = 1'b0;
    endcase
    return t;
  endfunction

endpackage

// File: rtl/jb_resolve_unit_if.sv
// Bus between the resolution unit and the fetch/execute stages.
//   fetch side : fetch_pc -> pred_taken, pred_target (combinational)
//   execute    : rs_valid, flush, opcode, funct3, pc, rs1, rs2, imm,
//                pred_taken_in, pred_target_in
//   result     : res_valid, res_taken, res_target, res_link,
//                res_mispredict, res_redirect_pc (registered)
// master = pipeline side, slave = resolution unit.
interface jb_resolve_unit_if #(parameter int XLEN = 32);
  logic            flush;
  logic [XLEN-1:0] fetch_pc;
  logic            pred_taken;
  logic [XLEN-1:0] pred_target;
  logic            rs_valid;
  logic [4:0]      opcode;
  logic [2:0]      funct3;
  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] rs1;
  logic [XLEN-1:0] rs2;
  logic [XLEN-1:0] imm;
  logic            pred_taken_in;
  logic [XLEN-1:0] pred_target_in;
  logic            res_valid;
  logic            res_taken;
  logic [XLEN-1:0] res_target;
  logic [XLEN-1:0] res_link;
  logic            res_mispredict;
  logic [XLEN-1:0] res_redirect_pc;

  modport master (
    output flush, fetch_pc, rs_valid, opcode, funct3, pc, rs1, rs2, imm,
           pred_taken_in, pred_target_in,
    input  pred_taken, pred_target, res_valid, res_taken, res_target,
           res_link, res_mispredict, res_redirect_pc
  );

  modport slave (
    input  flush, fetch_pc, rs_valid, opcode, funct3, pc, rs1, rs2, imm,
           pred_taken_in, pred_target_in,
    output pred_taken, pred_target, res_valid, res_taken, res_target,
           res_link, res_mispredict, res_redirect_pc
  );
endinterface

// File: rtl/jb_resolve_unit_btb.sv
// jb_btb: direct-mapped branch target buffer.
//   lookup_pc_i -> lookup_taken_o / lookup_target_o (combinational, pre-update state)
//   upd_*_i     -> write port; entry written on the next rising edge of clk
//   rst         -> synchronous, active-high; invalidates every entry
module jb_btb
  import jb_resolve_unit_pkg::*;
#(
  parameter int XLEN      = 32,
  parameter int BTB_DEPTH = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] lookup_pc_i,
  output logic            lookup_taken_o,
  output logic [XLEN-1:0] lookup_target_o,
  input  logic            upd_en_i,
  input  logic [XLEN-1:0] upd_pc_i,
  input  logic            upd_is_jump_i,
  input  logic            upd_is_branch_i,
  input  logic            upd_taken_i,
  input  logic [XLEN-1:0] upd_target_i
);
  localparam int IDX  = $clog2(BTB_DEPTH);
  localparam int TAGW = XLEN - IDX - 2;

  logic [BTB_DEPTH-1:0] valid_q;
  logic [BTB_DEPTH-1:0] jump_q;
  logic [TAGW-1:0]      tag_q    [BTB_DEPTH];
  logic [XLEN-1:0]      target_q [BTB_DEPTH];
  logic [1:0]           cnt_q    [BTB_DEPTH];

  logic [IDX-1:0]  l_idx, u_idx;
  logic [TAGW-1:0] u_tag;
  logic            l_hit, u_hit;
  logic            wr_en, wr_jump;
  logic [1:0]      wr_cnt;
  logic [XLEN-1:0] wr_target;

  // Instructions are word aligned, so the low two PC bits never address the table.
  logic unused_pc_lsbs;
  assign unused_pc_lsbs = ^{lookup_pc_i[1:0], upd_pc_i[1:0]};

  assign l_idx = lookup_pc_i[IDX+1:2];
  assign u_idx = upd_pc_i[IDX+1:2];
  assign u_tag = upd_pc_i[XLEN-1:IDX+2];
  assign l_hit = valid_q[l_idx] && (tag_q[l_idx] == lookup_pc_i[XLEN-1:IDX+2]);
  assign u_hit = valid_q[u_idx] && (tag_q[u_idx] == u_tag);

  assign lookup_taken_o  = l_hit && (jump_q[l_idx] || cnt_q[l_idx][1]);
  assign lookup_target_o = lookup_taken_o ? target_q[l_idx] : '0;

  always_comb begin
    wr_en     = 1'b0;
    wr_jump   = 1'b0;
    wr_cnt    = cnt_q[u_idx];
    wr_target = target_q[u_idx];
    if (upd_en_i) begin
      if (upd_is_jump_i) begin
        wr_en     = 1'b1;
        wr_jump   = 1'b1;
        wr_cnt    = 2'b11;
        wr_target = upd_target_i;
      end else if (upd_is_branch_i) begin
        if (u_hit) begin
          wr_en = 1'b1;
          if (upd_taken_i) begin
            wr_target = upd_target_i;
            if (cnt_q[u_idx] != 2'b11) wr_cnt = cnt_q[u_idx] + 2'd1;
          end else if (cnt_q[u_idx] != 2'b00) begin
            wr_cnt = cnt_q[u_idx] - 2'd1;
          end
        end else if (upd_taken_i) begin
          // A taken branch that misses evicts whatever shares its index.
          wr_en     = 1'b1;
          wr_cnt    = 2'b10;
          wr_target = upd_target_i;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
      jump_q  <= '0;
      for (int i = 0; i < BTB_DEPTH; i++) begin
        tag_q[i]    <= '0;
        target_q[i] <= '0;
        cnt_q[i]    <= 2'b00;
      end
    end else if (wr_en) begin
      valid_q[u_idx]  <= 1'b1;
      jump_q[u_idx]   <= wr_jump;
      tag_q[u_idx]    <= u_tag;
      target_q[u_idx] <= wr_target;
      cnt_q[u_idx]    <= wr_cnt;
    end
  end

endmodule

// File: rtl/jb_resolve_unit.sv
// jb_resolve_unit: resolves JAL/JALR/BRANCH one cycle after an accepted
// request and predicts taken/target for fetch_pc from the embedded BTB.
//   clk, rst : clock and synchronous active-high reset
//   jb_if    : slave side of jb_resolve_unit_if (requests, predictions, results)
module jb_resolve_unit
  import jb_resolve_unit_pkg::*;
#(
  parameter int XLEN      = 32,
  parameter int BTB_DEPTH = 16
) (
  input logic              clk,
  input logic              rst,
  jb_resolve_unit_if.slave jb_if
);
  logic            accept;
  logic            is_jump, is_branch;
  logic            taken_d, mispredict_d;
  logic [XLEN-1:0] target_d, link_d, redirect_d;

  logic            res_valid_q, res_taken_q, res_mispredict_q;
  logic [XLEN-1:0] res_target_q, res_link_q, res_redirect_q;

  assign accept    = jb_if.rs_valid && !jb_if.flush && !rst;
  assign is_jump   = (jb_if.opcode == OP_JAL) || (jb_if.opcode == OP_JALR);
  assign is_branch = (jb_if.opcode == OP_BRANCH);
  assign link_d    = jb_if.pc + XLEN'(4);

  always_comb begin
    target_d = '0;
    taken_d  = 1'b0;
    case (jb_if.opcode)
      OP_JAL: begin
        target_d = jb_if.pc + jb_if.imm;
        taken_d  = 1'b1;
      end
      OP_JALR: begin
        target_d = (jb_if.rs1 + jb_if.imm) & ~XLEN'(1);
        taken_d  = 1'b1;
      end
      OP_BRANCH: begin
        target_d = jb_if.pc + jb_if.imm;
        taken_d  = branch_taken(jb_if.funct3, jb_if.rs1 == jb_if.rs2,
                                $signed(jb_if.rs1) < $signed(jb_if.rs2),
                                jb_if.rs1 < jb_if.rs2);
      end
      default: ;
    endcase
  end

  // Target mismatch only matters when both sides agree the instruction is taken.
  assign mispredict_d = (taken_d != jb_if.pred_taken_in) ||
                        (taken_d && jb_if.pred_taken_in && (target_d != jb_if.pred_target_in));
  assign redirect_d   = taken_d ? target_d : link_d;

  jb_btb #(.XLEN(XLEN), .BTB_DEPTH(BTB_DEPTH)) u_btb (
    .clk             (clk),
    .rst             (rst),
    .lookup_pc_i     (jb_if.fetch_pc),
    .lookup_taken_o  (jb_if.pred_taken),
    .lookup_target_o (jb_if.pred_target),
    .upd_en_i        (accept),
    .upd_pc_i        (jb_if.pc),
    .upd_is_jump_i   (is_jump),
    .upd_is_branch_i (is_branch),
    .upd_taken_i     (taken_d),
    .upd_target_i    (target_d)
  );

  // Data fields only load on an accepted request so they hold while res_valid=0.
  always_ff @(posedge clk) begin
    if (rst) begin
      res_valid_q      <= 1'b0;
      res_taken_q      <= 1'b0;
      res_mispredict_q <= 1'b0;
      res_target_q     <= '0;
      res_link_q       <= '0;
      res_redirect_q   <= '0;
    end else begin
      res_valid_q <= accept;
      if (accept) begin
        res_taken_q      <= taken_d;
        res_mispredict_q <= mispredict_d;
        res_target_q     <= target_d;
        res_link_q       <= link_d;
        res_redirect_q   <= redirect_d;
      end
    end
  end

  assign jb_if.res_valid       = res_valid_q;
  assign jb_if.res_taken       = res_taken_q;
  assign jb_if.res_target      = res_target_q;
  assign jb_if.res_link        = res_link_q;
  assign jb_if.res_mispredict  = res_mispredict_q;
  assign jb_if.res_redirect_pc = res_redirect_q;

endmodule
